miv_jtag_dmi_master: RTL

MIV_JTAG_DMI_MASTER -- requirements
Module: miv_jtag_dmi_master

---
 rtl/miv_jtag_dmi_master.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/miv_jtag_dmi_master.sv
// JTAG master that bit-bangs RISC-V DMI accesses: one request scan, idle, one nop scan for the result.
// Optional TRST output and pre-TLR TAP reset phase under `MIV_JTAG_DMI_TRST_EN`.
module miv_jtag_dmi_master #(
    parameter int TCK_DIV     = 2,
    parameter int IDLE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [6:0]  CMD_ADDR,
    input  logic [31:0] CMD_DATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_DATA,
    output logic [1:0]  RSP_STATUS,
    output logic        TCK,
    output logic        TMS,
    output logic        TDI,
    input  logic        TDO
`ifdef MIV_JTAG_DMI_TRST_EN
    ,
    output logic        TRST
`endif
);

    localparam logic [4:0] IR_DMI   = 5'h11;
    localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);

    typedef enum logic [2:0] {
        S_TLR, S_IR, S_READY, S_DR_REQ, S_RTI, S_DR_RSP, S_DONE, S_TRST
    } state_t;

`ifdef MIV_JTAG_DMI_TRST_EN
    localparam state_t S_RESET = S_TRST;
`else
    localparam state_t S_RESET = S_TLR;
`endif

    state_t        state, state_nxt;
    logic [7:0]    div_cnt;
    logic [5:0]    step;          // TCK rising edges completed in the current state
    logic [40:0]   shreg;         // DR shifts out on TDI and fills from TDO
    logic          ir_loaded;
    logic          tck_q, tms_q, tdi_q;
    logic [31:0]   rsp_data;
    logic [1:0]    rsp_status;
    logic          tck_act, tick, rise, fall, seq_end, accept;

    function automatic logic [5:0] seq_len(state_t s);
        case (s)
            S_TRST:             seq_len = 6'd8;
            S_TLR:              seq_len = 6'd6;
            S_IR:               seq_len = 6'd11;
            S_DR_REQ, S_DR_RSP: seq_len = 6'd46;
            S_RTI:              seq_len = 6'(IDLE_CYCLES);
            default:            seq_len = 6'd0;
        endcase
    endfunction

    function automatic logic dr_shift(state_t s, logic [5:0] k);
        dr_shift = (s == S_DR_REQ || s == S_DR_RSP) && k >= 6'd3 && k <= 6'd43;
    endfunction

    // TMS to present for the k-th rising edge of a state
    function automatic logic tms_of(state_t s, logic [5:0] k);
        case (s)
            S_TRST:             tms_of = 1'b1;
            S_TLR:              tms_of = k < 6'd5;
            S_IR:               tms_of = k < 6'd2 || k == 6'd8 || k == 6'd9;
            S_DR_REQ, S_DR_RSP: tms_of = k == 6'd0 || k == 6'd43 || k == 6'd44;
            default:            tms_of = 1'b0;
        endcase
    endfunction

    function automatic logic tdi_of(state_t s, logic [5:0] k, logic b0);
        logic [5:0] ib;
        ib = k - 6'd4;
        if (s == S_IR && k >= 6'd4 && k <= 6'd8) tdi_of = IR_DMI[ib[2:0]];
        else if (dr_shift(s, k))                  tdi_of = b0;
        else                                      tdi_of = 1'b0;
    endfunction

    assign tck_act = state inside {S_TRST, S_TLR, S_IR, S_DR_REQ, S_RTI, S_DR_RSP};
    assign tick    = tck_act && div_cnt == DIV_LAST;
    assign rise    = tick && !tck_q;
    assign fall    = tick && tck_q;
    assign seq_end = fall && step == seq_len(state);
    assign accept  = state == S_READY && CMD_VALID;

    always_comb begin
        state_nxt = state;
        case (state)
            S_READY: if (CMD_VALID) state_nxt = S_DR_REQ;
            S_DONE:  state_nxt = S_READY;
            default: if (seq_end) begin
                case (state)
                    S_TRST:   state_nxt = S_TLR;
                    S_TLR:    state_nxt = ir_loaded ? S_READY : S_IR;
                    S_IR:     state_nxt = S_READY;
                    S_DR_REQ: state_nxt = S_RTI;
                    S_RTI:    state_nxt = S_DR_RSP;
                    S_DR_RSP: state_nxt = S_DONE;
                    default:  state_nxt = S_READY;
                endcase
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_RESET;
            div_cnt    <= '0;
            step       <= '0;
            shreg      <= '0;
            ir_loaded  <= 1'b0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= (tck_act && !tick) ? div_cnt + 8'd1 : 8'd0;
            if (tick) tck_q <= ~tck_q;
            if (rise) begin
                step <= step + 6'd1;
                if (dr_shift(state, step)) shreg <= {TDO, shreg[40:1]};
            end
            // State changes land on a TCK fall so TCK is already low when it parks
            if (fall) begin
                if (seq_end) begin
                    step  <= '0;
                    tms_q <= tms_of(state_nxt, 6'd0);
                    tdi_q <= 1'b0;
                end else begin
                    tms_q <= tms_of(state, step);
                    tdi_q <= tdi_of(state, step, shreg[0]);
                end
            end
            // TCK is parked low here, so TMS gets a full half-period of setup
            if (accept) begin
                shreg <= {CMD_ADDR, CMD_WRITE ? CMD_DATA : 32'h0, CMD_WRITE ? 2'b10 : 2'b01};
                tms_q <= 1'b1;
            end
            if (seq_end && state == S_IR)  ir_loaded <= 1'b1;
            if (seq_end && state == S_RTI) shreg <= '0;
            if (seq_end && state == S_DR_RSP) begin
                rsp_data   <= shreg[33:2];
                rsp_status <= shreg[1:0];
            end
        end
    end

`ifdef MIV_JTAG_DMI_TRST_EN
    always_ff @(posedge CLK) begin
        if (RESET) TRST <= 1'b0;
        else       TRST <= state_nxt != S_TRST;
    end
`endif

    assign CMD_READY  = state == S_READY;
    assign RSP_VALID  = state == S_DONE;
    assign RSP_DATA   = rsp_data;
    assign RSP_STATUS = rsp_status;
    assign TCK        = tck_q;
    assign TMS        = tms_q;
    assign TDI        = tdi_q;

endmodule
